// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_pkg
// Description : Shared types and constants for the instruction-fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_pkg;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_FETCH   = 3'd1,
        FS_CAPTURE = 3'd2,
        FS_ISSUE   = 3'd3,
        FS_WAIT    = 3'd4,
        FS_DONE    = 3'd5,
        FS_ERR     = 3'd6
    } fetch_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_SPURIOUS = 2'd2;
    localparam logic [1:0] ERR_ILL_PC   = 2'd3;

    localparam logic [31:0] HALT_INST_DEF = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/sp_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_fetch_ctrl_if
// Description : Instruction ROM port plus core issue/retire handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_fetch_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              in_valid;
    logic [31:0]       inst;
    logic              out_valid;
    logic [31:0]       inst_addr;

    modport master (
        output imem_en, imem_addr, in_valid, inst,
        input  imem_rdata, out_valid, inst_addr
    );

    modport slave (
        input  imem_en, imem_addr, in_valid, inst,
        output imem_rdata, out_valid, inst_addr
    );
endinterface
`default_nettype wire

// File: rtl/sp_lat_timer.sv
`default_nettype none
// ============================================================================
// Module      : sp_lat_timer
// Description : Loadable saturating up-counter with a terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_lat_timer #(
    parameter int WIDTH = 4,
    parameter int TERM  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Flags the last cycle in which a response is still accepted.
    assign o_tc = (r_count == WIDTH'(TERM - 1));
endmodule
`default_nettype wire

// File: rtl/sp_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_fetch_ctrl
// Description : Fetches from the instruction ROM, issues to the core, and
//               follows the core-returned next PC with timeout/halt checks.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_fetch_ctrl
    import sp_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          MAX_LAT   = 10,
    parameter int          MAX_INST  = 500,
    parameter logic [31:0] HALT_INST = HALT_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    sp_fetch_ctrl_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [15:0]            inst_cnt,
    output logic [31:0]            pc
);
    localparam logic [2:0] c_ST_IDLE    = 3'(FS_IDLE);
    localparam logic [2:0] c_ST_FETCH   = 3'(FS_FETCH);
    localparam logic [2:0] c_ST_CAPTURE = 3'(FS_CAPTURE);
    localparam logic [2:0] c_ST_ISSUE   = 3'(FS_ISSUE);
    localparam logic [2:0] c_ST_WAIT    = 3'(FS_WAIT);
    localparam logic [2:0] c_ST_DONE    = 3'(FS_DONE);
    localparam logic [2:0] c_ST_ERR     = 3'(FS_ERR);
    localparam int         c_TMR_W      = $clog2(MAX_LAT + 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [15:0] r_inst_cnt;
    logic [1:0]  r_err_code;
    logic        r_in_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        w_pc_ok;
    logic        w_spurious;
    logic        w_halt;
    logic        w_budget_hit;
    logic        w_tmo;
    logic [15:0] w_cnt_next;

    assign w_pc_ok      = (r_pc[1:0] == 2'b00) && (r_pc[31:ADDR_W+2] == '0);
    assign w_spurious   = bus.out_valid && ((r_state == c_ST_FETCH) ||
                          (r_state == c_ST_CAPTURE) || (r_state == c_ST_ISSUE));
    assign w_halt       = (bus.imem_rdata == HALT_INST);
    assign w_budget_hit = (({1'b0, r_inst_cnt} + 17'd1) == 17'(MAX_INST));
    assign w_cnt_next   = (r_inst_cnt == 16'hFFFF) ? r_inst_cnt : r_inst_cnt + 16'd1;

    sp_lat_timer #(
        .WIDTH (c_TMR_W),
        .TERM  (MAX_LAT)
    ) u_lat_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == c_ST_ISSUE),
        .i_load_val (c_TMR_W'(1)),
        .i_inc      ((r_state == c_ST_WAIT) && !bus.out_valid),
        .o_tc       (w_tmo)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) w_next_state = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (w_spurious || !w_pc_ok) w_next_state = c_ST_ERR;
                else                        w_next_state = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: begin
                if (w_spurious)  w_next_state = c_ST_ERR;
                else if (w_halt) w_next_state = c_ST_DONE;
                else             w_next_state = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                w_next_state = w_spurious ? c_ST_ERR : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (bus.out_valid) w_next_state = w_budget_hit ? c_ST_DONE : c_ST_FETCH;
                else if (w_tmo)    w_next_state = c_ST_ERR;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= '0;
            r_inst     <= '0;
            r_inst_cnt <= '0;
            r_err_code <= ERR_NONE;
            r_in_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_valid <= (w_next_state == c_ST_ISSUE);
            r_busy     <= (w_next_state == c_ST_FETCH) || (w_next_state == c_ST_CAPTURE) ||
                          (w_next_state == c_ST_ISSUE) || (w_next_state == c_ST_WAIT);
            r_done     <= (w_next_state == c_ST_DONE);
            r_err      <= (w_next_state == c_ST_ERR);
            case (r_state)
                c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                    if (start) begin
                        r_pc       <= '0;
                        r_inst_cnt <= '0;
                        r_err_code <= ERR_NONE;
                    end
                end
                c_ST_FETCH: begin
                    if (w_spurious)    r_err_code <= ERR_SPURIOUS;
                    else if (!w_pc_ok) r_err_code <= ERR_ILL_PC;
                end
                c_ST_CAPTURE: begin
                    // A halt word is never handed to the core.
                    if (w_spurious)  r_err_code <= ERR_SPURIOUS;
                    else if (!w_halt) r_inst    <= bus.imem_rdata;
                end
                c_ST_ISSUE: begin
                    if (w_spurious) r_err_code <= ERR_SPURIOUS;
                end
                c_ST_WAIT: begin
                    if (bus.out_valid) begin
                        r_pc       <= bus.inst_addr;
                        r_inst_cnt <= w_cnt_next;
                    end else if (w_tmo) begin
                        r_err_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Illegal PCs never reach the ROM.
    assign bus.imem_en   = (r_state == c_ST_FETCH) && w_pc_ok;
    assign bus.imem_addr = r_pc[ADDR_W+1:2];
    assign bus.in_valid  = r_in_valid;
    assign bus.inst      = r_inst;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign inst_cnt      = r_inst_cnt;
    assign pc            = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_sp_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_fetch_ctrl
// Description : Scoreboard bench for sp_fetch_ctrl with ROM and core models.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sp_fetch_ctrl;
    localparam int          c_MAX_INST = 4;
    localparam logic [31:0] c_ADDI = 32'h0050_0093;
    localparam logic [31:0] c_ADD  = 32'h0020_81B3;
    localparam logic [31:0] c_SW   = 32'h0031_A023;
    localparam logic [31:0] c_BEQ  = 32'h0000_8E63;
    localparam logic [31:0] c_XOR  = 32'h0020_C233;
    localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;

    typedef struct {
        bit          is_end;
        int          rel;
        logic [31:0] inst;
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [15:0] cnt;
        logic [31:0] pc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] inst_cnt;
    logic [31:0] pc;

    sp_fetch_ctrl_if #(.ADDR_W(12)) bus();

    sp_fetch_ctrl #(
        .ADDR_W    (12),
        .MAX_LAT   (10),
        .MAX_INST  (c_MAX_INST),
        .HALT_INST (c_HALT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .inst_cnt (inst_cnt),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          start_cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          en_cnt = 0;
    exp_t        sb[$];
    logic [31:0] rom [0:4095];

    int          core_lat = 2;
    bit          spur_mode = 1'b0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_from = '0;
    logic [31:0] ovr_to = '0;
    int          core_cnt = 0;
    bit          core_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= rom[bus.imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    task automatic exp_issue(input int rel, input logic [31:0] ins);
        exp_t e;
        e = '{is_end: 1'b0, rel: rel, inst: ins, done: 1'b0, err: 1'b0, code: 2'd0, cnt: 16'd0, pc: 32'd0};
        sb.push_back(e);
    endtask

    task automatic exp_end(input int rel, input logic d, input logic er, input logic [1:0] code,
                           input logic [15:0] cnt, input logic [31:0] p);
        exp_t e;
        e = '{is_end: 1'b1, rel: rel, inst: 32'd0, done: d, err: er, code: code, cnt: cnt, pc: p};
        sb.push_back(e);
    endtask

    // Core model: answers core_lat cycles after in_valid with the next PC.
    always @(negedge clk) begin
        bus.out_valid = 1'b0;
        if (rst) begin
            core_pend = 1'b0;
        end else begin
            if (core_pend) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_pend     = 1'b0;
                    bus.out_valid = 1'b1;
                    bus.inst_addr = (ovr_en && pc == ovr_from) ? ovr_to : pc + 32'd4;
                end
            end
            if (bus.in_valid) begin
                if (spur_mode) begin
                    bus.out_valid = 1'b1;
                    bus.inst_addr = pc + 32'd4;
                end else if (core_lat > 0) begin
                    core_pend = 1'b1;
                    core_cnt  = core_lat;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every issue and on every run completion.
    logic mon_prev_done = 1'b0;
    logic mon_prev_err  = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.imem_en) en_cnt++;
        if (bus.in_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_issue: inst %0h at cycle %0d, none expected", bus.inst, cyc - start_cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_kind", {31'd0, mon_e.is_end}, 32'd0);
                chk("issue_cycle", cyc - start_cyc, mon_e.rel);
                chk("issue_inst", bus.inst, mon_e.inst);
            end
        end
        if ((done && !mon_prev_done) || (err && !mon_prev_err)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_end: done=%0b err=%0b at cycle %0d", done, err, cyc - start_cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("end_kind", {31'd0, mon_e.is_end}, 32'd1);
                chk("end_cycle", cyc - start_cyc, mon_e.rel);
                chk("end_done", {31'd0, done}, {31'd0, mon_e.done});
                chk("end_err", {31'd0, err}, {31'd0, mon_e.err});
                chk("end_code", {30'd0, err_code}, {30'd0, mon_e.code});
                chk("end_cnt", {16'd0, inst_cnt}, {16'd0, mon_e.cnt});
                chk("end_pc", pc, mon_e.pc);
            end
        end
        mon_prev_done = done;
        mon_prev_err  = err;
    end

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
    endtask

    task automatic run_start();
        @(negedge clk);
        start  = 1'b1;
        en_cnt = 0;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc - 1;
    endtask

    task automatic wait_end(input int budget);
        int i;
        i = 0;
        while (!(done || err) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("run_end", {31'd0, done | err}, 32'd1);
        @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_cnt", {16'd0, inst_cnt}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_in_valid", {31'd0, bus.in_valid}, 32'd0);
        rst = 1'b0;

        // Straight-line program, core latency 2.
        rom[0] = c_ADDI; rom[1] = c_ADD; rom[2] = c_SW; rom[3] = c_HALT;
        exp_issue(3, c_ADDI); exp_issue(8, c_ADD); exp_issue(13, c_SW);
        exp_end(18, 1'b1, 1'b0, 2'd0, 16'd3, 32'd12);
        run_start();
        wait_end(60);

        // Taken branch at 0x4 redirects to 0x20.
        clear_rom();
        rom[0] = c_ADDI; rom[1] = c_BEQ; rom[8] = c_XOR; rom[9] = c_HALT;
        ovr_en = 1'b1; ovr_from = 32'h4; ovr_to = 32'h20;
        exp_issue(3, c_ADDI); exp_issue(8, c_BEQ); exp_issue(13, c_XOR);
        exp_end(18, 1'b1, 1'b0, 2'd0, 16'd3, 32'h24);
        run_start();
        wait_end(60);
        ovr_en = 1'b0;

        // Silent core: timeout exactly 10 cycles after in_valid.
        clear_rom();
        rom[0] = c_ADD; rom[1] = c_HALT;
        core_lat = 0;
        exp_issue(3, c_ADD);
        exp_end(13, 1'b0, 1'b1, 2'd1, 16'd0, 32'd0);
        run_start();
        wait_end(60);

        // Response on the last allowed cycle is accepted.
        core_lat = 9;
        exp_issue(3, c_ADD);
        exp_end(15, 1'b1, 1'b0, 2'd0, 16'd1, 32'd4);
        run_start();
        wait_end(60);

        // Misaligned next PC.
        core_lat = 2;
        ovr_en = 1'b1; ovr_from = 32'h0; ovr_to = 32'h6;
        exp_issue(3, c_ADD);
        exp_end(7, 1'b0, 1'b1, 2'd3, 16'd1, 32'h6);
        run_start();
        wait_end(60);
        chk("ill_pc_imem_en", en_cnt, 32'd1);

        // Next PC beyond the ROM.
        ovr_to = 32'h4000;
        exp_issue(3, c_ADD);
        exp_end(7, 1'b0, 1'b1, 2'd3, 16'd1, 32'h4000);
        run_start();
        wait_end(60);
        chk("oob_pc_imem_en", en_cnt, 32'd1);
        ovr_en = 1'b0;

        // out_valid during ISSUE.
        spur_mode = 1'b1;
        exp_issue(3, c_ADD);
        exp_end(4, 1'b0, 1'b1, 2'd2, 16'd0, 32'd0);
        run_start();
        wait_end(60);
        spur_mode = 1'b0;

        // Asynchronous reset in WAIT of the second instruction.
        clear_rom();
        rom[0] = c_ADDI; rom[1] = c_ADD; rom[2] = c_HALT;
        exp_issue(3, c_ADDI); exp_issue(8, c_ADD);
        run_start();
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_pc", pc, 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cnt", {16'd0, inst_cnt}, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_inst", bus.inst, 32'd0);
        chk("arst_code", {30'd0, err_code}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_sb", sb.size(), 32'd0);
        chk("post_rst_idle", {30'd0, busy, done | err}, 32'd0);

        // Endless loop stops at the instruction budget, then restarts cleanly.
        clear_rom();
        rom[0] = c_ADD;
        ovr_en = 1'b1; ovr_from = 32'h0; ovr_to = 32'h0;
        for (int r = 0; r < 2; r++) begin
            exp_issue(3, c_ADD); exp_issue(8, c_ADD); exp_issue(13, c_ADD); exp_issue(18, c_ADD);
            exp_end(21, 1'b1, 1'b0, 2'd0, 16'd4, 32'd0);
            run_start();
            chk("restart_cnt", {16'd0, inst_cnt}, 32'd0);
            chk("restart_busy", {31'd0, busy}, 32'd1);
            wait_end(80);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
